// File: rtl/imm_gen_stage_pkg.sv
// Shared immediate-format codes, base opcodes (inst[6:2]) and RVC quadrant/funct3
// constants for the ID-stage immediate generator.
package imm_gen_stage_pkg;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_type_e;

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;

    localparam logic [1:0] RVC_Q0 = 2'b00;
    localparam logic [1:0] RVC_Q1 = 2'b01;
    localparam logic [1:0] RVC_Q2 = 2'b10;

    localparam logic [2:0] C_F3_ADDI4SPN = 3'b000;
    localparam logic [2:0] C_F3_LW       = 3'b010;
    localparam logic [2:0] C_F3_SW       = 3'b110;
    localparam logic [2:0] C_F3_ADDI     = 3'b000;
    localparam logic [2:0] C_F3_JAL      = 3'b001;
    localparam logic [2:0] C_F3_LI       = 3'b010;
    localparam logic [2:0] C_F3_LUI      = 3'b011;
    localparam logic [2:0] C_F3_J        = 3'b101;
    localparam logic [2:0] C_F3_BEQZ     = 3'b110;
    localparam logic [2:0] C_F3_BNEZ     = 3'b111;
    localparam logic [2:0] C_F3_LWSP     = 3'b010;
    localparam logic [2:0] C_F3_SWSP     = 3'b110;

endpackage

// File: rtl/imm_gen_stage_imm_extract.sv
// Combinational immediate extraction: instruction + PC to sign-extended immediate,
// format code, PC-relative target, compressed and illegal flags.
module imm_extract
    import imm_gen_stage_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter bit          HAS_RVC = 1'b1
) (
    input  logic [31:0]     inst_i,
    input  logic [XLEN-1:0] pc_i,
    output logic [XLEN-1:0] imm_o,
    output logic [2:0]      imm_type_o,
    output logic [XLEN-1:0] target_o,
    output logic            is_compressed_o,
    output logic            illegal_o
);

    logic tgt_en;

    always_comb begin
        imm_o           = '0;
        imm_type_o      = IMM_NONE;
        is_compressed_o = 1'b0;
        illegal_o       = 1'b0;
        tgt_en          = 1'b0;
        if (inst_i[1:0] == 2'b11) begin
            case (inst_i[6:2])
                OPC_JALR, OPC_LOAD, OPC_OP_IMM: begin
                    imm_type_o = IMM_I;
                    imm_o      = {{(XLEN-12){inst_i[31]}}, inst_i[31:20]};
                end
                OPC_STORE: begin
                    imm_type_o = IMM_S;
                    imm_o      = {{(XLEN-12){inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
                end
                OPC_BRANCH: begin
                    imm_type_o = IMM_B;
                    tgt_en     = 1'b1;
                    imm_o      = {{(XLEN-13){inst_i[31]}}, inst_i[31], inst_i[7],
                                  inst_i[30:25], inst_i[11:8], 1'b0};
                end
                OPC_JAL: begin
                    imm_type_o = IMM_J;
                    tgt_en     = 1'b1;
                    imm_o      = {{(XLEN-21){inst_i[31]}}, inst_i[31], inst_i[19:12],
                                  inst_i[20], inst_i[30:21], 1'b0};
                end
                OPC_LUI, OPC_AUIPC: begin
                    imm_type_o = IMM_U;
                    tgt_en     = (inst_i[6:2] == OPC_AUIPC);
                    imm_o      = {{(XLEN-32){inst_i[31]}}, inst_i[31:12], 12'h000};
                end
                OPC_OP: ;
                default: illegal_o = 1'b1;
            endcase
        end else if (HAS_RVC) begin
            is_compressed_o = 1'b1;
            // Unlisted 16-bit encodings stay NONE; the full decoder owns their legality.
            case (inst_i[1:0])
                RVC_Q0: begin
                    case (inst_i[15:13])
                        C_F3_ADDI4SPN: begin
                            imm_type_o = IMM_I;
                            imm_o = {{(XLEN-10){1'b0}}, inst_i[10:7], inst_i[12:11],
                                     inst_i[5], inst_i[6], 2'b00};
                        end
                        C_F3_LW, C_F3_SW: begin
                            imm_type_o = (inst_i[15:13] == C_F3_SW) ? IMM_S : IMM_I;
                            imm_o = {{(XLEN-7){1'b0}}, inst_i[5], inst_i[12:10],
                                     inst_i[6], 2'b00};
                        end
                        default: ;
                    endcase
                end
                RVC_Q1: begin
                    case (inst_i[15:13])
                        C_F3_ADDI, C_F3_LI: begin
                            imm_type_o = IMM_I;
                            imm_o = {{(XLEN-6){inst_i[12]}}, inst_i[12], inst_i[6:2]};
                        end
                        C_F3_JAL, C_F3_J: begin
                            // funct3 001 is C.ADDIW rather than C.JAL on RV64
                            if (XLEN == 64 && inst_i[15:13] == C_F3_JAL) begin
                                imm_type_o = IMM_I;
                                imm_o = {{(XLEN-6){inst_i[12]}}, inst_i[12], inst_i[6:2]};
                            end else begin
                                imm_type_o = IMM_J;
                                tgt_en     = 1'b1;
                                imm_o = {{(XLEN-12){inst_i[12]}}, inst_i[12], inst_i[8],
                                         inst_i[10:9], inst_i[6], inst_i[7], inst_i[2],
                                         inst_i[11], inst_i[5:3], 1'b0};
                            end
                        end
                        C_F3_LUI: begin
                            if (inst_i[11:7] == 5'd2) begin
                                imm_type_o = IMM_I;
                                imm_o = {{(XLEN-10){inst_i[12]}}, inst_i[12], inst_i[4:3],
                                         inst_i[5], inst_i[2], inst_i[6], 4'b0000};
                            end else begin
                                imm_type_o = IMM_U;
                                imm_o = {{(XLEN-18){inst_i[12]}}, inst_i[12], inst_i[6:2],
                                         12'h000};
                            end
                        end
                        C_F3_BEQZ, C_F3_BNEZ: begin
                            imm_type_o = IMM_B;
                            tgt_en     = 1'b1;
                            imm_o = {{(XLEN-9){inst_i[12]}}, inst_i[12], inst_i[6:5],
                                     inst_i[2], inst_i[11:10], inst_i[4:3], 1'b0};
                        end
                        default: ;
                    endcase
                end
                RVC_Q2: begin
                    case (inst_i[15:13])
                        C_F3_LWSP: begin
                            imm_type_o = IMM_I;
                            imm_o = {{(XLEN-8){1'b0}}, inst_i[3:2], inst_i[12],
                                     inst_i[6:4], 2'b00};
                        end
                        C_F3_SWSP: begin
                            imm_type_o = IMM_S;
                            imm_o = {{(XLEN-8){1'b0}}, inst_i[8:7], inst_i[12:9], 2'b00};
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end else begin
            illegal_o = 1'b1;
        end
        target_o = tgt_en ? (pc_i + imm_o) : '0;
    end

endmodule

// File: rtl/imm_gen_stage.sv
// ID-stage immediate generator: combinational extract feeding a two-entry
// valid/ready skid buffer (output register plus one skid register).
module imm_gen_stage
    import imm_gen_stage_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter bit          HAS_RVC = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     inst_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] imm_o,
    output logic [2:0]      imm_type_o,
    output logic [XLEN-1:0] target_o,
    output logic            is_compressed_o,
    output logic            illegal_o
);

    localparam int unsigned PW = 2 * XLEN + 5;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [PW-1:0]   out_q, out_d;
    logic [PW-1:0]   skid_q, skid_d;

    logic [XLEN-1:0] x_imm, x_target;
    logic [2:0]      x_type;
    logic            x_comp, x_ill;
    logic [PW-1:0]   dec;
    logic            accept, drain;

    imm_extract #(
        .XLEN    (XLEN),
        .HAS_RVC (HAS_RVC)
    ) u_imm_extract (
        .inst_i          (inst_i),
        .pc_i            (pc_i),
        .imm_o           (x_imm),
        .imm_type_o      (x_type),
        .target_o        (x_target),
        .is_compressed_o (x_comp),
        .illegal_o       (x_ill)
    );

    assign dec         = {x_imm, x_type, x_target, x_comp, x_ill};
    assign in_ready_o  = (state_q != ST_FULL) & ~flush_i;
    assign out_valid_o = (state_q != ST_EMPTY);
    assign accept      = in_valid_i & in_ready_o;
    assign drain       = out_valid_o & out_ready_i;

    assign {imm_o, imm_type_o, target_o, is_compressed_o, illegal_o} = out_q;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        out_d   = dec;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        out_d = dec;
                    end else if (accept) begin
                        skid_d  = dec;
                        state_d = ST_FULL;
                    end else if (drain) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (drain) begin
                        out_d   = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed scoreboard bench for imm_gen_stage: RV32/RVC instance checked in full,
// RV64 and no-RVC instances checked in lockstep on imm and illegal flag.
module tb_imm_gen_stage;

    typedef struct {
        logic [31:0] imm;
        logic [2:0]  typ;
        logic [31:0] tgt;
        logic        c;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [63:0] pc64;

    logic        in_ready, o_valid, o_c, o_ill;
    logic [31:0] o_imm, o_tgt;
    logic [2:0]  o_type;

    logic        in_ready64, o_valid64, o_c64, o_ill64;
    logic [63:0] o_imm64, o_tgt64;
    logic [2:0]  o_type64;

    logic        in_ready_nr, o_valid_nr, o_c_nr, o_ill_nr;
    logic [31:0] o_imm_nr, o_tgt_nr;
    logic [2:0]  o_type_nr;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    assign pc64 = {32'h0, pc};

    always #5 clk = ~clk;

    imm_gen_stage #(.XLEN(32), .HAS_RVC(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(in_ready), .inst_i(inst), .pc_i(pc), .out_valid_o(o_valid),
        .out_ready_i(out_ready), .imm_o(o_imm), .imm_type_o(o_type), .target_o(o_tgt),
        .is_compressed_o(o_c), .illegal_o(o_ill)
    );

    imm_gen_stage #(.XLEN(64), .HAS_RVC(1'b1)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(in_ready64), .inst_i(inst), .pc_i(pc64), .out_valid_o(o_valid64),
        .out_ready_i(out_ready), .imm_o(o_imm64), .imm_type_o(o_type64), .target_o(o_tgt64),
        .is_compressed_o(o_c64), .illegal_o(o_ill64)
    );

    imm_gen_stage #(.XLEN(32), .HAS_RVC(1'b0)) u_norvc (
        .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(in_ready_nr), .inst_i(inst), .pc_i(pc), .out_valid_o(o_valid_nr),
        .out_ready_i(out_ready), .imm_o(o_imm_nr), .imm_type_o(o_type_nr), .target_o(o_tgt_nr),
        .is_compressed_o(o_c_nr), .illegal_o(o_ill_nr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] i, input logic [31:0] p,
                           input logic [31:0] eimm, input logic [2:0] et,
                           input logic [31:0] etgt, input logic ec, input logic eill,
                           input bit push);
        exp_t e;
        inst     = i;
        pc       = p;
        in_valid = 1'b1;
        if (push) begin
            e.imm = eimm; e.typ = et; e.tgt = etgt; e.c = ec; e.ill = eill;
            sb.push_back(e);
        end
    endtask

    // Output monitor: a transfer happens at the next posedge when valid & ready here.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && o_valid && out_ready) begin
            n_checks++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL sb_underflow: observed output imm 0x%0h, expected no output", o_imm);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("imm",     64'(o_imm),  64'(e.imm));
                chk("type",    64'(o_type), 64'(e.typ));
                chk("target",  64'(o_tgt),  64'(e.tgt));
                chk("comp",    64'(o_c),    64'(e.c));
                chk("illegal", 64'(o_ill),  64'(e.ill));
                chk("imm64",   o_imm64,     {{32{e.imm[31]}}, e.imm});
                chk("ill_norvc", 64'(o_ill_nr), 64'(e.c | e.ill));
            end
        end
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        inst = '0; pc = '0;
        #12;
        chk("rst_valid",  64'(o_valid),  64'd0);
        chk("rst_ready",  64'(in_ready), 64'd1);
        chk("rst_imm",    64'(o_imm),    64'd0);
        chk("rst_type",   64'(o_type),   64'd0);
        chk("rst_target", 64'(o_tgt),    64'd0);
        chk("rst_comp",   64'(o_c),      64'd0);
        chk("rst_ill",    64'(o_ill),    64'd0);
        chk("rst_imm64",  o_imm64,       64'd0);
        rst_n = 1'b1;
        tick();

        // Full-rate stream of assorted formats
        present(32'hFFF00093, 32'h100,      32'hFFFFFFFF, 3'd1, 32'h0,        1'b0, 1'b0, 1); tick();
        present(32'h800000B7, 32'h104,      32'h80000000, 3'd4, 32'h0,        1'b0, 1'b0, 1); tick();
        present(32'hFE000CE3, 32'h200,      32'hFFFFFFF8, 3'd3, 32'h1F8,      1'b0, 1'b0, 1); tick();
        chk("stream_ready", 64'(in_ready), 64'd1);
        present(32'h001000EF, 32'h1000,     32'h00000800, 3'd5, 32'h1800,     1'b0, 1'b0, 1); tick();
        present(32'hFE112E23, 32'h10,       32'hFFFFFFFC, 3'd2, 32'h0,        1'b0, 1'b0, 1); tick();
        present(32'h12345297, 32'h400,      32'h12345000, 3'd4, 32'h12345400, 1'b0, 1'b0, 1); tick();
        present(32'h00001297, 32'hFFFFF000, 32'h00001000, 3'd4, 32'h0,        1'b0, 1'b0, 1); tick();
        present(32'h002081B3, 32'h20,       32'h0,        3'd0, 32'h0,        1'b0, 1'b0, 1); tick();
        present(32'h0000007F, 32'h24,       32'h0,        3'd0, 32'h0,        1'b0, 1'b1, 1); tick();
        present(32'h00005575, 32'h28,       32'hFFFFFFFD, 3'd1, 32'h0,        1'b1, 1'b0, 1); tick();
        present(32'h0000BFFD, 32'h100,      32'hFFFFFFFE, 3'd5, 32'hFE,       1'b1, 1'b0, 1); tick();
        present(32'h000050FE, 32'h30,       32'h000000FC, 3'd1, 32'h0,        1'b1, 1'b0, 1); tick();
        present(32'h0000DC75, 32'h300,      32'hFFFFFFFC, 3'd3, 32'h2FC,      1'b1, 1'b0, 1); tick();
        present(32'h00008082, 32'h34,       32'h0,        3'd0, 32'h0,        1'b1, 1'b0, 1); tick();
        chk("stream_valid", 64'(o_valid), 64'd1);
        in_valid = 1'b0;
        tick();
        tick();
        chk("stream_drained_valid", 64'(o_valid), 64'd0);
        chk("stream_drained_sb", 64'(sb.size()), 64'd0);

        // Backpressure: ready low for two cycles, skid fills, then drains in order
        present(32'hFFF00093, 32'h100, 32'hFFFFFFFF, 3'd1, 32'h0, 1'b0, 1'b0, 1); tick();
        present(32'hFE112E23, 32'h10,  32'hFFFFFFFC, 3'd2, 32'h0, 1'b0, 1'b0, 1);
        out_ready = 1'b0;
        tick();
        chk("full_ready", 64'(in_ready), 64'd0);
        chk("full_valid", 64'(o_valid),  64'd1);
        chk("hold_imm_1", 64'(o_imm),    64'hFFFFFFFF);
        present(32'h00005575, 32'h28, 32'hFFFFFFFD, 3'd1, 32'h0, 1'b1, 1'b0, 0);
        tick();
        chk("full_ready_2", 64'(in_ready), 64'd0);
        chk("hold_imm_2",   64'(o_imm),    64'hFFFFFFFF);
        chk("hold_type_2",  64'(o_type),   64'd1);
        out_ready = 1'b1;
        tick();
        chk("resume_ready", 64'(in_ready), 64'd1);
        chk("resume_valid", 64'(o_valid),  64'd1);
        present(32'h00005575, 32'h28,   32'hFFFFFFFD, 3'd1, 32'h0,    1'b1, 1'b0, 1); tick();
        chk("rate_valid_1", 64'(o_valid), 64'd1);
        present(32'h001000EF, 32'h1000, 32'h00000800, 3'd5, 32'h1800, 1'b0, 1'b0, 1); tick();
        chk("rate_valid_2", 64'(o_valid), 64'd1);
        in_valid = 1'b0;
        tick();
        chk("bp_empty_valid", 64'(o_valid), 64'd0);
        chk("bp_empty_sb", 64'(sb.size()), 64'd0);

        // Flush while FULL with a new instruction presented
        out_ready = 1'b0;
        present(32'hFE000CE3, 32'h200, 32'hFFFFFFF8, 3'd3, 32'h1F8, 1'b0, 1'b0, 1); tick();
        present(32'h12345297, 32'h400, 32'h12345000, 3'd4, 32'h12345400, 1'b0, 1'b0, 1); tick();
        chk("pre_flush_ready", 64'(in_ready), 64'd0);
        present(32'h0000007F, 32'h24, 32'h0, 3'd0, 32'h0, 1'b0, 1'b1, 0);
        flush = 1'b1;
        tick();
        sb.delete();
        chk("flush_valid",     64'(o_valid),  64'd0);
        chk("flush_ready_gate", 64'(in_ready), 64'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        chk("post_flush_ready", 64'(in_ready), 64'd1);
        chk("post_flush_valid", 64'(o_valid),  64'd0);
        tick();
        chk("flushed_never_out", 64'(o_valid), 64'd0);

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        present(32'hFE000CE3, 32'h200, 32'hFFFFFFF8, 3'd3, 32'h1F8, 1'b0, 1'b0, 1); tick();
        present(32'h001000EF, 32'h1000, 32'h00000800, 3'd5, 32'h1800, 1'b0, 1'b0, 1); tick();
        in_valid = 1'b0;
        chk("pre_rst_imm", 64'(o_imm), 64'hFFFFFFF8);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid",  64'(o_valid),  64'd0);
        chk("arst_ready",  64'(in_ready), 64'd1);
        chk("arst_imm",    64'(o_imm),    64'd0);
        chk("arst_target", 64'(o_tgt),    64'd0);
        chk("arst_imm64",  o_imm64,       64'd0);
        sb.delete();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("post_rst_valid", 64'(o_valid), 64'd0);

        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        chk("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
